mem_stage: RTL and testbench

- Pipeline MEM stage. Sits directly downstream of the execute stage and consumes its ALU result (address) and forwarded RegB (store data).
- Contains word-addressed data RAM and a memory-mapped peripheral block: timer with interrupt, LEDs and 7-segment digit register.
- Returns load data combinationally, so the MEM/WB register can latch it at the same clock edge.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_timer.sv | 46 ++++
 rtl/mem_stage.sv | 106 ++++++++++
 tb/tb_mem_stage.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: MMIO register offsets and TCON bits.
// Offset 0x14 (SYSTICK) is only live when MEM_SYSTICK_EN is defined.
package mem_stage_pkg;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_DIGITS  = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

endpackage

// File: rtl/mem_stage_if.sv
// Load/store bus between the execute stage and the MEM stage.
// ReadData is returned combinationally by the slave.
interface mem_stage_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemRead, MemWrite, Addr, WriteData,
        input  ReadData
    );

    modport slave (
        input  MemRead, MemWrite, Addr, WriteData,
        output ReadData
    );

endinterface

// File: rtl/mem_timer.sv
// Reloading timer: TH reload, TL count, TCON control/status, registered irq.
// A software write to a register overrides the timer update of that register only.
module mem_timer
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic wrap;

    assign wrap = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
            irq  <= 1'b0;
        end else begin
            if (we && off == OFF_TH)
                th <= wdata;

            if (we && off == OFF_TL)
                tl <= wdata;
            else if (tcon[TCON_EN])
                tl <= wrap ? th : tl + 32'd1;

            // status sets on wrap only when irq enable is on
            if (we && off == OFF_TCON)
                tcon <= wdata[2:0];
            else if (wrap && tcon[TCON_IE])
                tcon[TCON_IS] <= 1'b1;

            irq <= tcon[TCON_IS] & tcon[TCON_IE];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: word RAM, MMIO decode (timer, LEDs, 7-seg) and combinational load mux.
// Define MEM_SYSTICK_EN to add a free-running cycle counter at MMIO offset 0x14.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'h4000_0000
) (
    input  logic          clk,
    input  logic          reset,
    mem_stage_if.slave    bus,
    output logic [7:0]    led,
    output logic [11:0]   digits,
    output logic          irq
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_LIMIT = 32'(4 * RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];

    logic          ram_hit;
    logic          mmio_hit;
    logic [4:0]    off;
    logic [AW-1:0] idx;
    logic          mmio_we;
    logic [31:0]   th;
    logic [31:0]   tl;
    logic [2:0]    tcon;
    logic [31:0]   mmio_rd;
    logic [31:0]   rdata;

    assign ram_hit  = bus.Addr < RAM_LIMIT;
    assign mmio_hit = bus.Addr[31:5] == MMIO_BASE[31:5];
    assign off      = {bus.Addr[4:2], 2'b00};
    assign idx      = bus.Addr[AW+1:2];
    assign mmio_we  = bus.MemWrite && mmio_hit;

    always_ff @(posedge clk) begin
        if (bus.MemWrite && ram_hit)
            ram[idx] <= bus.WriteData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led    <= '0;
            digits <= '0;
        end else begin
            if (mmio_we && off == OFF_LED)
                led <= bus.WriteData[7:0];
            if (mmio_we && off == OFF_DIGITS)
                digits <= bus.WriteData[11:0];
        end
    end

`ifdef MEM_SYSTICK_EN
    logic [31:0] systick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            systick <= '0;
        else
            systick <= systick + 32'd1;
    end
`endif

    mem_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .we    (mmio_we),
        .off   (off),
        .wdata (bus.WriteData),
        .th    (th),
        .tl    (tl),
        .tcon  (tcon),
        .irq   (irq)
    );

    always_comb begin
        mmio_rd = '0;
        case (off)
            OFF_TH:      mmio_rd = th;
            OFF_TL:      mmio_rd = tl;
            OFF_TCON:    mmio_rd = {29'd0, tcon};
            OFF_LED:     mmio_rd = {24'd0, led};
            OFF_DIGITS:  mmio_rd = {20'd0, digits};
`ifdef MEM_SYSTICK_EN
            OFF_SYSTICK: mmio_rd = systick;
`endif
            default:     mmio_rd = '0;
        endcase
    end

    // RAM reads see the pre-edge array, so a same-cycle store returns old data
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            ram_hit:  rdata = ram[idx];
            mmio_hit: rdata = mmio_rd;
            default:  rdata = '0;
        endcase
    end

    assign bus.ReadData = bus.MemRead ? rdata : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Covers RAM, timer wrap/irq, write priority, LED/7-seg, decode holes, async reset.
module tb_mem_stage;

    localparam logic [31:0] MB = 32'h4000_0000;

    logic        clk;
    logic        reset;
    logic [7:0]  led;
    logic [11:0] digits;
    logic        irq;
    logic [31:0] d;
    logic [31:0] d2;
    int          checks;
    int          errors;

    mem_stage_if bus ();

    mem_stage dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .led    (led),
        .digits (digits),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b1;
        bus.Addr      = a;
        bus.WriteData = v;
        tick();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.MemRead = 1'b1;
        bus.Addr    = a;
        #1;
        v = bus.ReadData;
        bus.MemRead = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Addr      = '0;
        bus.WriteData = '0;
        #1;
        chk("rst_led", {24'd0, led}, 32'h0);
        chk("rst_digits", {20'd0, digits}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        rd(MB + 32'h04, d); chk("rst_tl", d, 32'h0);
        rd(MB + 32'h08, d); chk("rst_tcon", d, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        wr(32'h10, 32'h1234_5678);
        rd(32'h10, d); chk("ram_lw", d, 32'h1234_5678);
        rd(32'h13, d); chk("ram_lsb_ign", d, 32'h1234_5678);

        wr(32'h0, 32'h11);
        wr(32'h400, 32'h22);
        rd(32'h0, d); chk("ram_top_alias", d, 32'h11);
        rd(32'h400, d); chk("ram_oob", d, 32'h0);

        wr(32'h20, 32'h5);
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.Addr      = 32'h20;
        bus.WriteData = 32'hAAAA_0000;
        #1;
        chk("rw_old", bus.ReadData, 32'h5);
        tick();
        bus.MemWrite = 1'b0;
        #1;
        chk("rw_new", bus.ReadData, 32'hAAAA_0000);
        bus.MemRead = 1'b0;
        #1;
        chk("rd_gate", bus.ReadData, 32'h0);

        wr(MB + 32'h00, 32'hFFFF_FFFC);
        wr(MB + 32'h04, 32'hFFFF_FFFE);
        wr(MB + 32'h08, 32'h3);
        rd(MB + 32'h04, d); chk("tl_fe", d, 32'hFFFF_FFFE);
        tick();
        rd(MB + 32'h04, d); chk("tl_ff", d, 32'hFFFF_FFFF);
        tick();
        rd(MB + 32'h04, d); chk("tl_reload", d, 32'hFFFF_FFFC);
        rd(MB + 32'h08, d); chk("tcon_is", d, 32'h7);
        chk("irq_lag", {31'd0, irq}, 32'h0);
        tick();
        chk("irq_set", {31'd0, irq}, 32'h1);
        rd(MB + 32'h04, d); chk("tl_fd", d, 32'hFFFF_FFFD);
        wr(MB + 32'h08, 32'h3);
        rd(MB + 32'h08, d); chk("tcon_clr", d, 32'h3);
        chk("irq_hold", {31'd0, irq}, 32'h1);
        tick();
        chk("irq_drop", {31'd0, irq}, 32'h0);
        rd(MB + 32'h04, d); chk("tl_pre_ovf", d, 32'hFFFF_FFFF);
        wr(MB + 32'h08, 32'h3);
        rd(MB + 32'h08, d); chk("ovf_tcon_wr", d, 32'h3);
        rd(MB + 32'h04, d); chk("ovf_tl_reload", d, 32'hFFFF_FFFC);
        tick();
        chk("ovf_no_irq", {31'd0, irq}, 32'h0);
        wr(MB + 32'h08, 32'h0);

        wr(MB + 32'h0C, 32'h1FF);
        chk("led_out", {24'd0, led}, 32'hFF);
        rd(MB + 32'h0C, d); chk("led_rd", d, 32'hFF);
        wr(MB + 32'h10, 32'hFABC);
        chk("dig_out", {20'd0, digits}, 32'hABC);
        rd(MB + 32'h10, d); chk("dig_rd", d, 32'hABC);
        wr(MB + 32'h18, 32'h55);
        rd(MB + 32'h18, d); chk("mmio_hole", d, 32'h0);
        wr(32'h8000_0000, 32'hDEAD_BEEF);
        rd(32'h8000_0000, d); chk("unmapped_rd", d, 32'h0);
        chk("unmapped_led", {24'd0, led}, 32'hFF);
        rd(32'h10, d); chk("unmapped_ram", d, 32'h1234_5678);

`ifdef MEM_SYSTICK_EN
        rd(MB + 32'h14, d);
        tick();
        rd(MB + 32'h14, d2);
        chk("systick_inc", d2 - d, 32'h1);
        wr(MB + 32'h14, 32'h0);
        rd(MB + 32'h14, d2);
        chk("systick_ro", d2 - d, 32'h2);
`else
        rd(MB + 32'h14, d); chk("systick_off", d, 32'h0);
`endif

        wr(MB + 32'h04, 32'h100);
        wr(MB + 32'h08, 32'h1);
        rd(MB + 32'h04, d); chk("tl_run", d, 32'h100);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_led", {24'd0, led}, 32'h0);
        chk("arst_digits", {20'd0, digits}, 32'h0);
        chk("arst_irq", {31'd0, irq}, 32'h0);
        rd(MB + 32'h04, d); chk("arst_tl", d, 32'h0);
        rd(MB + 32'h08, d); chk("arst_tcon", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
